// File: rtl/btn_pkg.sv
// btn_pkg: shared event encoding and sizing helper for the button event controller.
package btn_pkg;
  localparam int EVT_W = 2;
  typedef enum logic [EVT_W-1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_t;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/btn_chan.sv
// btn_chan: one button - 2-FF synchroniser, tick-based debounce and hold/long/repeat detection.
module btn_chan
  import btn_pkg::*;
#(
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_lvl,
  output logic o_evt_stb,
  output evt_t o_evt_type
);
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(REP_TICKS + 1);
  logic          r_s1, r_s2, r_lvl, r_long;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;
  logic [RW-1:0] r_rph;
  logic          w_deb_done, w_htick, w_long, w_rep;
  assign w_deb_done = (r_s2 != r_lvl) && (r_dcnt == DW'(DEB_TICKS));
  assign w_htick    = r_lvl && i_tick;
  assign w_long     = w_htick && !r_long && (r_hcnt == HW'(LONG_TICKS - 1));
  assign w_rep      = w_htick && r_long && (r_rph == RW'(REP_TICKS - 1));
  assign o_lvl      = r_lvl;
  assign o_evt_stb  = w_deb_done || w_long || w_rep;
  // A debounce edge outranks a hold event landing in the same cycle.
  assign o_evt_type = w_deb_done ? (r_lvl ? EVT_RELEASE : EVT_PRESS) :
                      w_long     ? EVT_LONG : EVT_REPEAT;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_lvl  <= 1'b0;
      r_dcnt <= '0;
      r_hcnt <= '0;
      r_long <= 1'b0;
      r_rph  <= '0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      if (r_s2 == r_lvl || w_deb_done) r_dcnt <= '0;
      else if (i_tick) r_dcnt <= r_dcnt + 1'b1;
      if (w_deb_done) r_lvl <= !r_lvl;
      if (!r_lvl || w_deb_done) begin
        r_hcnt <= '0;
        r_long <= 1'b0;
        r_rph  <= '0;
      end else if (i_tick) begin
        r_hcnt <= (r_hcnt == '1) ? r_hcnt : r_hcnt + 1'b1;
        if (w_long) r_long <= 1'b1;
        if (r_long) r_rph <= w_rep ? '0 : r_rph + 1'b1;
      end
    end
  end
endmodule

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl: debounced button events, per-button pending slots and a round-robin
// arbiter feeding a single valid/ready event port.
module btn_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN      = 5,
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_US    = 1000,
  parameter int DEB_TICKS  = 20,
  parameter int LONG_TICKS = 1000,
  parameter int REP_TICKS  = 200,
  localparam int IDW       = clog2_min1(N_BTN)
) (
  input  logic             CLK_100_I,
  input  logic             RSTN_I,
  input  logic [N_BTN-1:0] BTN_I,
  output logic [N_BTN-1:0] BTN_LVL_O,
  output logic             EVT_VALID_O,
  input  logic             EVT_READY_I,
  output logic [IDW-1:0]   EVT_ID_O,
  output logic [EVT_W-1:0] EVT_TYPE_O,
  output logic             EVT_DROP_O
);
  localparam int PRESC = CLK_HZ / 1_000_000 * TICK_US;
  localparam int PW    = clog2_min1(PRESC);
  logic [PW-1:0]    r_pcnt;
  logic [N_BTN-1:0] r_sv;
  evt_t             r_st [N_BTN];
  logic [IDW-1:0]   r_ptr, r_id;
  evt_t             r_type;
  logic             r_valid, r_drop;
  logic             w_tick, w_free, w_gnt;
  logic [IDW-1:0]   w_gidx;
  logic [N_BTN-1:0] w_stb, w_drop;
  evt_t             w_type [N_BTN];
  assign w_tick      = (r_pcnt == PW'(PRESC - 1));
  assign w_free      = !r_valid || EVT_READY_I;
  assign EVT_VALID_O = r_valid;
  assign EVT_ID_O    = r_id;
  assign EVT_TYPE_O  = r_type;
  assign EVT_DROP_O  = r_drop;
  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    btn_chan #(
      .DEB_TICKS (DEB_TICKS),
      .LONG_TICKS(LONG_TICKS),
      .REP_TICKS (REP_TICKS)
    ) u_chan (
      .i_clk     (CLK_100_I),
      .i_rst_n   (RSTN_I),
      .i_tick    (w_tick),
      .i_btn     (BTN_I[g]),
      .o_lvl     (BTN_LVL_O[g]),
      .o_evt_stb (w_stb[g]),
      .o_evt_type(w_type[g])
    );
  end
  // Scan from the far end so the slot closest to r_ptr is the one left standing.
  always_comb begin
    w_gnt  = 1'b0;
    w_gidx = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (w_free && r_sv[(int'(r_ptr) + i) % N_BTN]) begin
        w_gnt  = 1'b1;
        w_gidx = IDW'((int'(r_ptr) + i) % N_BTN);
      end
  end
  always_comb begin
    w_drop = '0;
    for (int i = 0; i < N_BTN; i++)
      w_drop[i] = w_stb[i] && r_sv[i] && !(w_gnt && w_gidx == IDW'(i));
  end
  always_ff @(posedge CLK_100_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      r_pcnt  <= '0;
      r_sv    <= '0;
      r_ptr   <= '0;
      r_id    <= '0;
      r_type  <= EVT_PRESS;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
      for (int i = 0; i < N_BTN; i++) r_st[i] <= EVT_PRESS;
    end else begin
      r_pcnt <= w_tick ? '0 : r_pcnt + 1'b1;
      r_drop <= |w_drop;
      for (int i = 0; i < N_BTN; i++)
        if (w_stb[i]) begin
          r_sv[i] <= 1'b1;
          r_st[i] <= w_type[i];
        end else if (w_gnt && w_gidx == IDW'(i)) r_sv[i] <= 1'b0;
      if (w_gnt) begin
        r_valid <= 1'b1;
        r_id    <= w_gidx;
        r_type  <= r_st[w_gidx];
        r_ptr   <= IDW'((int'(w_gidx) + 1) % N_BTN);
      end else if (EVT_READY_I) r_valid <= 1'b0;
    end
  end
endmodule
